// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve -> play -> point -> game-over flow, score keeping,
// ball gating, serve direction and the game-over blink phase for the display.
// Ports: clk/rst_n; start, player_point, cpu_point pulses in; player_score,
// cpu_score, ball_en, serve_dir, game_over, winner, blink out (all registered).
module pong_match_controller #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_CYCLES = 50000000,
  parameter int POINT_CYCLES = 25000000,
  parameter int BLINK_CYCLES = 12500000,
  parameter int TW           = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       player_point,
  input  logic       cpu_point,
  output logic [2:0] player_score,
  output logic [2:0] cpu_score,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_CYCLES - 1);
  localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_CYCLES - 1);
  localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);
  localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [2:0]    player_score_nxt;
  logic [2:0]    cpu_score_nxt;
  logic          ball_en_nxt;
  logic          serve_dir_nxt;
  logic          game_over_nxt;
  logic          winner_nxt;
  logic          blink_nxt;

  logic          scored;
  logic          win_hit;
  logic          timer_zero;
  logic [2:0]    player_inc;
  logic [2:0]    cpu_inc;

  // The player's pulse wins a same-cycle tie, so the win test follows the
  // player's score whenever player_point is set.
  assign scored     = player_point | cpu_point;
  assign player_inc = player_score + 3'd1;
  assign cpu_inc    = cpu_score + 3'd1;
  assign win_hit    = player_point ? (player_inc == WIN) : (cpu_inc == WIN);
  assign timer_zero = (timer == '0);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      player_score <= 3'd0;
      cpu_score    <= 3'd0;
      ball_en      <= 1'b0;
      serve_dir    <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
      blink        <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      player_score <= player_score_nxt;
      cpu_score    <= cpu_score_nxt;
      ball_en      <= ball_en_nxt;
      serve_dir    <= serve_dir_nxt;
      game_over    <= game_over_nxt;
      winner       <= winner_nxt;
      blink        <= blink_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_SERVE;
      S_SERVE: if (timer_zero) state_nxt = S_PLAY;
      S_PLAY:  if (scored)     state_nxt = win_hit ? S_OVER : S_POINT;
      S_POINT: if (timer_zero) state_nxt = S_SERVE;
      S_OVER:  if (start)      state_nxt = S_SERVE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the shared timer
  always_comb begin
    timer_nxt        = timer;
    player_score_nxt = player_score;
    cpu_score_nxt    = cpu_score;
    ball_en_nxt      = ball_en;
    serve_dir_nxt    = serve_dir;
    game_over_nxt    = game_over;
    winner_nxt       = winner;
    blink_nxt        = blink;
    case (state)
      S_IDLE: begin
        if (start) begin
          player_score_nxt = 3'd0;
          cpu_score_nxt    = 3'd0;
          timer_nxt        = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        ball_en_nxt = 1'b0;
        if (!timer_zero) timer_nxt = timer - 1'b1;
      end
      S_PLAY: begin
        if (player_point) begin
          player_score_nxt = player_inc;
          serve_dir_nxt    = 1'b1;
        end else if (cpu_point) begin
          cpu_score_nxt = cpu_inc;
          serve_dir_nxt = 1'b0;
        end
        if (scored) begin
          ball_en_nxt = 1'b0;
          if (win_hit) begin
            game_over_nxt = 1'b1;
            winner_nxt    = ~player_point;
            blink_nxt     = 1'b1;
            timer_nxt     = BLINK_LOAD;
          end else begin
            timer_nxt = POINT_LOAD;
          end
        end else begin
          // First PLAY cycle lifts ball_en one edge after leaving SERVE.
          ball_en_nxt = 1'b1;
        end
      end
      S_POINT: begin
        ball_en_nxt = 1'b0;
        if (timer_zero) timer_nxt = SERVE_LOAD;
        else            timer_nxt = timer - 1'b1;
      end
      S_OVER: begin
        ball_en_nxt = 1'b0;
        if (start) begin
          player_score_nxt = 3'd0;
          cpu_score_nxt    = 3'd0;
          game_over_nxt    = 1'b0;
          winner_nxt       = 1'b0;
          blink_nxt        = 1'b0;
          timer_nxt        = SERVE_LOAD;
        end else if (timer_zero) begin
          blink_nxt = ~blink;
          timer_nxt = BLINK_LOAD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        // Corrupted encoding: park safely and fall back to IDLE.
        ball_en_nxt   = 1'b0;
        game_over_nxt = 1'b0;
        blink_nxt     = 1'b0;
        timer_nxt     = '0;
      end
    endcase
  end

endmodule
